// File: rtl/msk_share_decoder_if.sv
// ---------------------------------------------------------------------------
// msk_share_decoder_if
//
// Purpose:
//   Handshake bundle for the masked-share decoder. It carries a d-share
//   masked input word in and the recombined plain word out. Each direction
//   has its own valid/ready pair.
//
// Parameters:
//   d      number of shares per masked bit
//   count  number of masked bits per word
//
// Signals:
//   in_data   [count*d] masked word, bit i*d+j = share j of bit i
//   in_valid  in_data valid
//   in_ready  decoder can accept a word
//   out_data  [count]   recombined plain word
//   out_valid out_data valid
//   out_ready downstream accepts out_data
//
// Modports:
//   master  upstream/downstream side (drives in_*, out_ready)
//   slave   decoder side
// ---------------------------------------------------------------------------
interface msk_share_decoder_if #(
    parameter int d     = 2,
    parameter int count = 1
);
    logic [count*d-1:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic [count-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/msk_share_decoder.sv
// ---------------------------------------------------------------------------
// msk_share_decoder
//
// Purpose:
//   Sequential unmasking unit. It accepts one d-share Boolean-masked word and
//   recombines the shares of each bit into its plain value, which is the XOR
//   of all shares. Shares are folded one per cycle through a registered
//   accumulator. No combinational XOR tree therefore spans all shares of a
//   bit.
//
//   Share 0 is used as-is. Any inversion convention, such as masked NOT, is
//   already carried inside the shares.
//
// Parameters:
//   d      number of shares (>= 1)
//   count  number of masked bits per word
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset (priority over all handshakes)
//   bus  msk_share_decoder_if.slave: in_data/in_valid/in_ready,
//        out_data/out_valid/out_ready
//
// Optional feature (macro MSK_SHARE_DECODER_ZEROIZE_EN):
//   defined   - each buffer slot is cleared the cycle after its share is
//               folded; the buffer and accumulator are cleared on the output
//               handshake; out_data reads 0 whenever out_valid is 0.
//   undefined - the buffers keep their contents until the next capture, and
//               out_data holds the last delivered word.
// ---------------------------------------------------------------------------
module msk_share_decoder #(
    parameter int d     = 2,
    parameter int count = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    msk_share_decoder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int                CNT_W     = (d > 1) ? $clog2(d) : 1;
    // The first share folded in ACC is share 1. For d=1, ACC is never
    // entered, so the counter stays at 0.
    localparam logic [CNT_W-1:0]  CNT_FIRST = (d > 1) ? CNT_W'(1) : '0;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(d - 1);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [count-1:0][d-1:0]     r_buf;        // [bit][share], same layout as in_data
    logic [count-1:0]            r_acc;
    logic [CNT_W-1:0]            r_cnt;

    logic                        w_in_ready;
    logic                        w_out_valid;
    logic                        w_in_fire;
    logic                        w_out_fire;
    logic                        w_fold;
    logic [count-1:0]            w_share0;     // share 0 of every bit, from in_data
    logic [count-1:0]            w_share_cnt;  // share r_cnt of every bit, from r_buf

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = (d > 1) ? ACC : OUT;
                end
            end
            ACC: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_in_fire  = (r_state == IDLE) && bus.in_valid;
    assign w_out_fire = (r_state == OUT) && bus.out_ready;
    assign w_fold     = (r_state == ACC);

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;

    // -----------------------------------------------------------------------
    // Share selection
    // -----------------------------------------------------------------------
    always_comb begin
        w_share0    = '0;
        w_share_cnt = '0;
        for (int i = 0; i < count; i++) begin
            w_share0[i]    = bus.in_data[i*d];
            w_share_cnt[i] = r_buf[i][r_cnt];
        end
    end

`ifdef MSK_SHARE_DECODER_ZEROIZE_EN
    // Share 0 is folded at capture time, so its slot is never written.
    logic [count-1:0][d-1:0] w_capture;

    always_comb begin
        w_capture = bus.in_data;
        for (int i = 0; i < count; i++) begin
            w_capture[i][0] = 1'b0;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Datapath: share buffer, accumulator, step counter
    // -----------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments only. All
    // registers then see the pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the share buffer is cleared on reset on purpose. Masked
            // data from an aborted word must not survive the reset.
            r_buf <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_in_fire) begin
            r_acc <= w_share0;
            r_cnt <= CNT_FIRST;
`ifdef MSK_SHARE_DECODER_ZEROIZE_EN
            r_buf <= w_capture;
`else
            r_buf <= bus.in_data;
`endif
        end else if (w_fold) begin
            r_acc <= r_acc ^ w_share_cnt;
            // The counter stops at the last share instead of wrapping.
            if (r_cnt != CNT_LAST) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
`ifdef MSK_SHARE_DECODER_ZEROIZE_EN
            for (int i = 0; i < count; i++) begin
                r_buf[i][r_cnt] <= 1'b0;
            end
`endif
        end
`ifdef MSK_SHARE_DECODER_ZEROIZE_EN
        else if (w_out_fire) begin
            r_buf <= '0;
            r_acc <= '0;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Output data
    // -----------------------------------------------------------------------
`ifdef MSK_SHARE_DECODER_ZEROIZE_EN
    assign bus.out_data = (r_state == OUT) ? r_acc : '0;
`else
    // The accumulator holds partial sums while a new word is folded. A
    // separate copy therefore keeps the last delivered word visible outside
    // OUT.
    logic [count-1:0] r_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_out_fire) begin
            r_hold <= r_acc;
        end
    end

    assign bus.out_data = (r_state == OUT) ? r_acc : r_hold;
`endif

endmodule
